alarm_ringer: RTL and testbench

- Consumes the alarm time from the alarm setter (BCD digits min_1sa, min_10sa, hr_1sa, hr_10sa) and the running clock time (BCD digits min_1s, min_10s, hr_1s, hr_10s).
- Rings the buzzer output with a beep pattern when the two times become equal; supports snooze, stop and a ring timeout.
- Sits beside the alarm setter in the top level and drives the alarm1 LED/buzzer pin.

---
 rtl/alarm_ringer.sv | 211 +++++++++++++++++++++
 tb/tb_alarm_ringer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// Alarm ringer: compares the running time against the alarm time and drives the
// buzzer with a beep pattern, with snooze, stop and ring-timeout handling.
module alarm_ringer #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int BEEP_DIV    = 25_000_000,
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       alon,
   input  logic       snooze,
   input  logic       stop,
   input  logic [3:0] min_1s,
   input  logic [3:0] min_10s,
   input  logic [3:0] hr_1s,
   input  logic [3:0] hr_10s,
   input  logic [3:0] min_1sa,
   input  logic [3:0] min_10sa,
   input  logic [3:0] hr_1sa,
   input  logic [3:0] hr_10sa,
   output logic       alarm1,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] state
);

   localparam int TICK_W = (TICK_DIV > 1)       ? $clog2(TICK_DIV)       : 1;
   localparam int BEEP_W = (BEEP_DIV > 1)       ? $clog2(BEEP_DIV)       : 1;
   localparam int RING_W = (RING_SECS > 1)      ? $clog2(RING_SECS)      : 1;
   localparam int SNZ_W  = (SNOOZE_SECS > 1)    ? $clog2(SNOOZE_SECS)    : 1;
   localparam int USED_W = (MAX_SNOOZE + 1 > 1) ? $clog2(MAX_SNOOZE + 1) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_DIV - 1);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
   localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SECS - 1);
   localparam logic [USED_W-1:0] USED_MAX  = USED_W'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   state_t            state_reg;
   logic [TICK_W-1:0] tick_cnt_reg;
   logic [BEEP_W-1:0] beep_cnt_reg;
   logic [RING_W-1:0] ring_cnt_reg;
   logic [SNZ_W-1:0]  snz_cnt_reg;
   logic [USED_W-1:0] used_reg;
   logic              beep_phase_reg;
   logic              match_q_reg;
   logic              alarm1_reg;
   logic              ringing_reg;
   logic              snoozing_reg;

   logic              tick;
   logic              match;
   logic              match_rise;
   logic              snz_p;
   logic              stp_p;

   // Button conditioning: index 0 is snooze, index 1 is stop.
   logic [1:0] btn_raw;
   logic [1:0] btn_pulse;

   assign btn_raw = {stop, snooze};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic [2:0] sync_reg;
         logic       last_reg;

         always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
               sync_reg <= '0;
               last_reg <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[1:0], btn_raw[gi]};
               last_reg <= sync_reg[2];
            end
         end

         assign btn_pulse[gi] = sync_reg[2] & ~last_reg;
      end
   endgenerate

   assign snz_p = btn_pulse[0];
   assign stp_p = btn_pulse[1];

   // Digit-wise time comparison; both sides are BCD so equal digits mean equal times.
   logic [15:0] now_digits;
   logic [15:0] alarm_digits;
   logic [3:0]  digit_eq;

   assign now_digits   = {hr_10s, hr_1s, min_10s, min_1s};
   assign alarm_digits = {hr_10sa, hr_1sa, min_10sa, min_1sa};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign digit_eq[gi] = (now_digits[gi*4 +: 4] == alarm_digits[gi*4 +: 4]);
      end
   endgenerate

   assign match      = &digit_eq;
   assign match_rise = match & ~match_q_reg;
   assign tick       = (tick_cnt_reg == TICK_LAST);

   // match_q starts high so a time that already matches at reset cannot ring.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         tick_cnt_reg <= '0;
         match_q_reg  <= 1'b1;
      end else begin
         match_q_reg <= match;
         if (tick) begin
            tick_cnt_reg <= '0;
         end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         beep_cnt_reg   <= '0;
         beep_phase_reg <= 1'b0;
         ring_cnt_reg   <= '0;
         snz_cnt_reg    <= '0;
         used_reg       <= '0;
         alarm1_reg     <= 1'b0;
         ringing_reg    <= 1'b0;
         snoozing_reg   <= 1'b0;
      end else begin
         alarm1_reg   <= (state_reg == RINGING) && beep_phase_reg;
         ringing_reg  <= (state_reg == RINGING);
         snoozing_reg <= (state_reg == SNOOZE);

         if (state_reg == RINGING) begin
            if (beep_cnt_reg == BEEP_LAST) begin
               beep_cnt_reg   <= '0;
               beep_phase_reg <= ~beep_phase_reg;
            end else begin
               beep_cnt_reg <= beep_cnt_reg + BEEP_W'(1);
            end
         end

         if (!alon) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= ARMED;
               end
               ARMED: begin
                  if (match_rise) begin
                     state_reg      <= RINGING;
                     ring_cnt_reg   <= '0;
                     used_reg       <= '0;
                     beep_cnt_reg   <= '0;
                     beep_phase_reg <= 1'b1;
                  end
               end
               RINGING: begin
                  // A refused snooze falls through so the ring timeout still runs.
                  if (stp_p) begin
                     state_reg <= ARMED;
                  end else if (snz_p && (used_reg < USED_MAX)) begin
                     state_reg   <= SNOOZE;
                     used_reg    <= used_reg + USED_W'(1);
                     snz_cnt_reg <= '0;
                  end else if (tick) begin
                     if (ring_cnt_reg == RING_LAST) begin
                        state_reg <= ARMED;
                     end else begin
                        ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
                     end
                  end
               end
               SNOOZE: begin
                  if (stp_p) begin
                     state_reg <= ARMED;
                  end else if (tick) begin
                     if (snz_cnt_reg == SNZ_LAST) begin
                        state_reg      <= RINGING;
                        ring_cnt_reg   <= '0;
                        beep_cnt_reg   <= '0;
                        beep_phase_reg <= 1'b1;
                     end else begin
                        snz_cnt_reg <= snz_cnt_reg + SNZ_W'(1);
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign alarm1   = alarm1_reg;
   assign ringing  = ringing_reg;
   assign snoozing = snoozing_reg;
   assign state    = state_reg;

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios plus a randomized soak, each cycle
// compared against a reference model built from time arithmetic and input history.
module tb_alarm_ringer;

   localparam int TICK_DIV    = 10;
   localparam int BEEP_DIV    = 4;
   localparam int RING_SECS   = 5;
   localparam int SNOOZE_SECS = 3;
   localparam int MAX_SNOOZE  = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       alon;
   logic       snooze;
   logic       stop;
   logic [3:0] min_1s, min_10s, hr_1s, hr_10s;
   logic [3:0] min_1sa, min_10sa, hr_1sa, hr_10sa;
   logic       alarm1;
   logic       ringing;
   logic       snoozing;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alarm_ringer #(
      .TICK_DIV   (TICK_DIV),
      .BEEP_DIV   (BEEP_DIV),
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS),
      .MAX_SNOOZE (MAX_SNOOZE)
   ) dut (
      .clk_100MHz(clk),
      .reset     (reset),
      .alon      (alon),
      .snooze    (snooze),
      .stop      (stop),
      .min_1s    (min_1s),
      .min_10s   (min_10s),
      .hr_1s     (hr_1s),
      .hr_10s    (hr_10s),
      .min_1sa   (min_1sa),
      .min_10sa  (min_10sa),
      .hr_1sa    (hr_1sa),
      .hr_10sa   (hr_10sa),
      .alarm1    (alarm1),
      .ringing   (ringing),
      .snoozing  (snoozing),
      .state     (state)
   );

   // Reference model: times as minutes of day, seconds counted from an edge count,
   // beep phase from elapsed edges since ring entry, button pulses from sample history.
   int now_min;
   int alarm_min;
   int m_mode;
   int m_ring_s;
   int m_snz_s;
   int m_used;
   int m_entry;
   int m_edges;
   int m_prev_match;
   int m_alarm;
   int m_ringing;
   int m_snoozing;
   bit snz_h[4];
   bit stp_h[4];

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_now(input int t);
      int h, m;
      now_min = t;
      h = t / 60;
      m = t % 60;
      hr_10s  = 4'(h / 10);
      hr_1s   = 4'(h % 10);
      min_10s = 4'(m / 10);
      min_1s  = 4'(m % 10);
   endtask

   task automatic set_alarm(input int t);
      int h, m;
      alarm_min = t;
      h = t / 60;
      m = t % 60;
      hr_10sa  = 4'(h / 10);
      hr_1sa   = 4'(h % 10);
      min_10sa = 4'(m / 10);
      min_1sa  = 4'(m % 10);
   endtask

   task automatic model_reset();
      m_mode       = 0;
      m_ring_s     = 0;
      m_snz_s      = 0;
      m_used       = 0;
      m_entry      = 0;
      m_edges      = 0;
      m_prev_match = 1;
      m_alarm      = 0;
      m_ringing    = 0;
      m_snoozing   = 0;
      for (int i = 0; i < 4; i++) begin
         snz_h[i] = 1'b0;
         stp_h[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit tick, m, rise, sp, tp;
      tick = (m_edges % TICK_DIV) == TICK_DIV - 1;
      m    = (now_min == alarm_min);
      rise = m && (m_prev_match == 0);
      sp   = snz_h[2] && !snz_h[3];
      tp   = stp_h[2] && !stp_h[3];

      m_alarm    = (m_mode == 2) && (((m_edges - m_entry) / BEEP_DIV) % 2 == 0);
      m_ringing  = (m_mode == 2);
      m_snoozing = (m_mode == 3);

      if (!alon) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: m_mode = 1;
            1: if (rise) begin
                  m_mode   = 2;
                  m_ring_s = 0;
                  m_used   = 0;
                  m_entry  = m_edges + 1;
               end
            2: if (tp) m_mode = 1;
               else if (sp && m_used < MAX_SNOOZE) begin
                  m_mode  = 3;
                  m_used  = m_used + 1;
                  m_snz_s = 0;
               end else if (tick) begin
                  m_ring_s = m_ring_s + 1;
                  if (m_ring_s == RING_SECS) m_mode = 1;
               end
            default: if (tp) m_mode = 1;
               else if (tick) begin
                  m_snz_s = m_snz_s + 1;
                  if (m_snz_s == SNOOZE_SECS) begin
                     m_mode   = 2;
                     m_ring_s = 0;
                     m_entry  = m_edges + 1;
                  end
               end
         endcase
      end

      for (int i = 3; i > 0; i--) begin
         snz_h[i] = snz_h[i-1];
         stp_h[i] = stp_h[i-1];
      end
      snz_h[0]     = snooze;
      stp_h[0]     = stop;
      m_prev_match = m;
      m_edges      = m_edges + 1;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
      check("state", state, m_mode);
      check("alarm1", alarm1, m_alarm);
      check("ringing", ringing, m_ringing);
      check("snoozing", snoozing, m_snoozing);
   endtask

   task automatic wait_state(input int target, input int budget, input string tag);
      int k = 0;
      while (state !== 2'(target) && k < budget) begin
         cycle();
         k++;
      end
      check(tag, state, target);
   endtask

   task automatic ring_now();
      set_now((alarm_min + 1) % 1440);
      repeat (2) cycle();
      set_now(alarm_min);
      wait_state(2, 4, "ring_start");
   endtask

   task automatic press_snooze(input int hold);
      snooze = 1'b1;
      repeat (hold) cycle();
      snooze = 1'b0;
      repeat (2) cycle();
   endtask

   task automatic apply_reset();
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("rst_alarm1", alarm1, 0);
      check("rst_state", state, 0);
      check("rst_ringing", ringing, 0);
      check("rst_snoozing", snoozing, 0);
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   initial begin
      int k, r;
      reset  = 1'b0;
      alon   = 1'b0;
      snooze = 1'b0;
      stop   = 1'b0;
      set_now(0);
      set_alarm(7 * 60 + 30);
      model_reset();
      #1 reset = 1'b1;
      #1;
      check("init_state", state, 0);
      check("init_alarm1", alarm1, 0);
      check("init_ringing", ringing, 0);
      check("init_snoozing", snoozing, 0);
      repeat (2) cycle();
      reset = 1'b0;

      // Scenario 1: 07:29 -> 07:30 rings, beeps, then times out.
      alon = 1'b1;
      set_now(alarm_min - 1);
      repeat (3) cycle();
      set_now(alarm_min);
      cycle();
      check("s1_ring_state", state, 2);
      cycle();
      check("s1_alarm_on", alarm1, 1);
      wait_state(1, RING_SECS * TICK_DIV + 5, "s1_timeout");
      cycle();
      check("s1_alarm_off", alarm1, 0);

      // Scenario 2: stop held for 20 cycles, no re-ring while time still matches.
      ring_now();
      repeat ($urandom_range(0, 12)) cycle();
      stop = 1'b1;
      repeat (20) cycle();
      stop = 1'b0;
      repeat (40) cycle();
      check("s2_no_rering", state, 1);

      // Scenario 3: two snoozes honoured, third ignored, then timeout.
      set_alarm($urandom_range(0, 1439));
      ring_now();
      press_snooze($urandom_range(1, 8));
      wait_state(3, 10, "s3_snooze1");
      wait_state(2, SNOOZE_SECS * TICK_DIV + 10, "s3_rering1");
      press_snooze($urandom_range(1, 8));
      wait_state(3, 10, "s3_snooze2");
      wait_state(2, SNOOZE_SECS * TICK_DIV + 10, "s3_rering2");
      press_snooze($urandom_range(1, 8));
      repeat (2) cycle();
      check("s3_third_ignored", state, 2);
      wait_state(1, RING_SECS * TICK_DIV + 10, "s3_timeout");

      // Scenario 4: alon rises while the time already matches.
      alon = 1'b0;
      repeat (2) cycle();
      check("s4_idle", state, 0);
      alon = 1'b1;
      repeat (30) cycle();
      check("s4_no_ring", state, 1);
      set_now((alarm_min + 1) % 1440);
      repeat (2) cycle();
      set_now(alarm_min);
      wait_state(2, 4, "s4_wrap_ring");

      // Scenario 5: drop alon mid-ring, then reset mid-ring.
      repeat ($urandom_range(0, 6)) cycle();
      alon = 1'b0;
      cycle();
      check("s5_alon_off", state, 0);
      cycle();
      check("s5_alarm_off", alarm1, 0);
      alon = 1'b1;
      repeat (2) cycle();
      ring_now();
      k = 0;
      while (alarm1 !== 1'b1 && k < 10) begin
         cycle();
         k++;
      end
      check("s5_beep_high", alarm1, 1);
      apply_reset();
      repeat (30) cycle();
      check("s5_after_reset", state, 1);

      // Scenario 6: snooze and stop together, stop wins.
      ring_now();
      repeat ($urandom_range(1, 5)) cycle();
      snooze = 1'b1;
      stop   = 1'b1;
      repeat (5) cycle();
      snooze = 1'b0;
      stop   = 1'b0;
      repeat (3) cycle();
      check("s6_stop_wins", state, 1);

      // Randomized soak.
      set_alarm($urandom_range(0, 1439));
      set_now($urandom_range(0, 1439));
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 5) set_now(alarm_min);
         else if (r < 9) set_now($urandom_range(0, 1439));
         else if (r < 13) snooze = ~snooze;
         else if (r == 13) stop = ~stop;
         else if (r == 14) alon = ~alon;
         else if (r == 15) alon = 1'b1;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
